// File: rtl/bcd_mon_pkg.sv
// Shared types and constants for the BCD sequence monitor.
// Digit limits, FSM states, error codes and the tens-digit wrap helpers.
package bcd_mon_pkg;

   localparam logic [3:0] MAX_DIGIT = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACQ  = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_BADVAL = 2'd1;
   localparam logic [1:0] ERR_SEQ    = 2'd2;

   function automatic logic [3:0] tens_up(input logic [3:0] t);
      return (t == MAX_DIGIT) ? 4'd0 : t + 4'd1;
   endfunction

   function automatic logic [3:0] tens_dn(input logic [3:0] t);
      return (t == 4'd0) ? MAX_DIGIT : t - 4'd1;
   endfunction

endpackage

// File: rtl/bcd_seq_monitor_if.sv
// Sample bus from the observed mod-10 counter into the monitor.
interface bcd_seq_monitor_if;
   logic       in_valid;
   logic [3:0] in_digit;
   logic       load_seen;

   modport master (output in_valid, in_digit, load_seen);
   modport slave  (input  in_valid, in_digit, load_seen);
endinterface

// File: rtl/bcd_seq_monitor_mod10_step.sv
// Combinational mod-10 successor / predecessor of a BCD digit.
module mod10_step
   import bcd_mon_pkg::*;
(
   input  logic [3:0] d,
   output logic [3:0] succ,
   output logic [3:0] pred
);

   assign succ = (d == MAX_DIGIT) ? 4'd0 : d + 4'd1;
   assign pred = (d == 4'd0) ? MAX_DIGIT : d - 4'd1;

endmodule

// File: rtl/bcd_seq_monitor.sv
// Watches a mod-10 counter, infers its direction, counts wraps in a tens digit
// and flags out-of-range values and illegal steps.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | no reference digit held
//   ACQ     | reference digit held, direction not yet known
//   LOCK    | direction known, tracking steps and wraps
module bcd_seq_monitor
   import bcd_mon_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   bcd_seq_monitor_if.slave     smp,
   input  logic                 clr,
   output logic                 locked,
   output logic                 dir,
   output logic [3:0]           tens,
   output logic                 err_pulse,
   output logic [1:0]           err_code,
   output logic [ERR_CNT_W-1:0] err_count
);

   state_t     state, state_nxt;
   logic [3:0] prev, prev_nxt, tens_nxt;
   logic [3:0] succ_prev, pred_prev;
   logic       dir_nxt, err_nxt;
   logic [1:0] code_nxt;

   mod10_step u_step (
      .d    (prev),
      .succ (succ_prev),
      .pred (pred_prev)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         prev      <= 4'd0;
         dir       <= 1'b0;
         locked    <= 1'b0;
         tens      <= 4'd0;
         err_pulse <= 1'b0;
         err_code  <= ERR_NONE;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         prev      <= prev_nxt;
         dir       <= dir_nxt;
         locked    <= (state_nxt == ST_LOCK);
         err_pulse <= err_nxt;
         err_code  <= code_nxt;
         // clr wins over a coincident wrap or error increment
         if (clr) begin
            tens      <= 4'd0;
            err_count <= '0;
         end else begin
            tens <= tens_nxt;
            if (err_nxt && (err_count != '1))
               err_count <= err_count + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      prev_nxt  = prev;
      dir_nxt   = dir;
      tens_nxt  = tens;
      err_nxt   = 1'b0;
      code_nxt  = ERR_NONE;
      if (smp.in_valid) begin
         if (smp.in_digit > MAX_DIGIT) begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_BADVAL;
            state_nxt = ST_IDLE;
         end else if (smp.load_seen) begin
            prev_nxt  = smp.in_digit;
            state_nxt = ST_ACQ;
         end else begin
            case (state)
               ST_IDLE: begin
                  prev_nxt  = smp.in_digit;
                  state_nxt = ST_ACQ;
               end
               ST_ACQ: begin
                  prev_nxt = smp.in_digit;
                  if (smp.in_digit == succ_prev) begin
                     dir_nxt   = 1'b0;
                     state_nxt = ST_LOCK;
                  end else if (smp.in_digit == pred_prev) begin
                     dir_nxt   = 1'b1;
                     state_nxt = ST_LOCK;
                  end else if (smp.in_digit != prev) begin
                     err_nxt  = 1'b1;
                     code_nxt = ERR_SEQ;
                  end
               end
               ST_LOCK: begin
                  if (smp.in_digit == prev) begin
                     prev_nxt = prev;
                  end else if (!dir && (smp.in_digit == succ_prev)) begin
                     prev_nxt = smp.in_digit;
                     if (prev == MAX_DIGIT) tens_nxt = tens_up(tens);
                  end else if (dir && (smp.in_digit == pred_prev)) begin
                     prev_nxt = smp.in_digit;
                     if (prev == 4'd0) tens_nxt = tens_dn(tens);
                  end else if ((!dir && (prev == MAX_DIGIT) && (smp.in_digit == pred_prev)) ||
                               (dir && (prev == 4'd0) && (smp.in_digit == succ_prev))) begin
                     // counter bounced off its end stop and reversed
                     dir_nxt  = ~dir;
                     prev_nxt = smp.in_digit;
                  end else begin
                     err_nxt   = 1'b1;
                     code_nxt  = ERR_SEQ;
                     prev_nxt  = smp.in_digit;
                     state_nxt = ST_ACQ;
                  end
               end
               default: state_nxt = ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bcd_seq_monitor.sv
// Self-checking bench: directed scenarios plus a randomized stream against a reference model.
module tb_bcd_seq_monitor;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clr = 1'b0;

   bcd_seq_monitor_if sif ();

   logic       locked8, dir8, pulse8, locked2, dir2, pulse2;
   logic [3:0] tens8, tens2;
   logic [1:0] code8, code2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;

   bcd_seq_monitor #(.ERR_CNT_W(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .smp(sif.slave), .clr(clr),
      .locked(locked8), .dir(dir8), .tens(tens8),
      .err_pulse(pulse8), .err_code(code8), .err_count(cnt8)
   );

   bcd_seq_monitor #(.ERR_CNT_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .smp(sif.slave), .clr(clr),
      .locked(locked2), .dir(dir2), .tens(tens2),
      .err_pulse(pulse2), .err_code(code2), .err_count(cnt2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model: mode 0 = no reference, 1 = acquiring, 2 = tracking
   int m_mode, m_prev, m_dir, m_tens, m_cnt8, m_cnt2, e_pulse, e_code;

   function automatic void model_reset();
      m_mode = 0; m_prev = 0; m_dir = 0; m_tens = 0;
      m_cnt8 = 0; m_cnt2 = 0; e_pulse = 0; e_code = 0;
   endfunction

   function automatic void model_step(input bit v, input int d, input bit ld, input bit c);
      int delta;
      e_pulse = 0;
      e_code  = 0;
      if (v) begin
         delta = (d - m_prev + 10) % 10;
         if (d > 9) begin
            e_pulse = 1; e_code = 1; m_mode = 0;
         end else if (ld) begin
            m_prev = d; m_mode = 1;
         end else if (m_mode == 0) begin
            m_prev = d; m_mode = 1;
         end else if (m_mode == 1) begin
            if (delta == 1) begin m_dir = 0; m_mode = 2; end
            else if (delta == 9) begin m_dir = 1; m_mode = 2; end
            else if (delta != 0) begin e_pulse = 1; e_code = 2; end
            m_prev = d;
         end else begin
            if (delta == 0) begin
            end else if (m_dir == 0 && delta == 1) begin
               if (d == 0) m_tens = (m_tens + 1) % 10;
               m_prev = d;
            end else if (m_dir == 1 && delta == 9) begin
               if (d == 9) m_tens = (m_tens + 9) % 10;
               m_prev = d;
            end else if ((m_dir == 0 && m_prev == 9 && d == 8) ||
                         (m_dir == 1 && m_prev == 0 && d == 1)) begin
               m_dir = 1 - m_dir; m_prev = d;
            end else begin
               e_pulse = 1; e_code = 2; m_mode = 1; m_prev = d;
            end
         end
      end
      if (e_pulse != 0) begin
         if (m_cnt8 < 255) m_cnt8++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      if (c) begin m_tens = 0; m_cnt8 = 0; m_cnt2 = 0; end
   endfunction

   task automatic drive(input bit v, input int d, input bit ld, input bit c);
      sif.in_valid  = v;
      sif.in_digit  = d[3:0];
      sif.load_seen = ld;
      clr           = c;
      @(posedge clk); #1;
      model_step(v, d, ld, c);
      sif.in_valid = 1'b0; sif.load_seen = 1'b0; clr = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      sif.in_valid = 1'b1; sif.in_digit = 4'd4; sif.load_seen = 1'b0; clr = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b1; sif.in_valid = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if ({locked8, dir8, pulse8} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {locked8, dir8, pulse8}); end
      checks++; if (tens8 !== 4'd0 || code8 !== 2'd0) begin errors++; $display("FAIL reset_tens_code: got %0d/%0d want 0/0", tens8, code8); end
      checks++; if (cnt8 !== 8'd0 || cnt2 !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d/%0d want 0/0", cnt8, cnt2); end
   endtask

   task automatic test_lock_up();
      do_reset();
      drive(1, 3, 0, 0);
      checks++; if (locked8 !== 1'b0) begin errors++; $display("FAIL acq_not_locked: got %b want 0", locked8); end
      drive(1, 4, 0, 0);
      checks++; if (locked8 !== 1'b1 || dir8 !== 1'b0) begin errors++; $display("FAIL lock_up: got locked=%b dir=%b want 1/0", locked8, dir8); end
      drive(1, 5, 0, 0);
      checks++; if (locked8 !== 1'b1 || pulse8 !== 1'b0 || cnt8 !== 8'd0) begin errors++; $display("FAIL track_up: got %b/%b/%0d want 1/0/0", locked8, pulse8, cnt8); end
   endtask

   task automatic test_wrap();
      do_reset();
      drive(1, 7, 0, 0); drive(1, 8, 0, 0); drive(1, 9, 0, 0);
      checks++; if (tens8 !== 4'd0) begin errors++; $display("FAIL tens_pre_wrap: got %0d want 0", tens8); end
      drive(1, 0, 0, 0);
      checks++; if (tens8 !== 4'd1) begin errors++; $display("FAIL tens_wrap_up: got %0d want 1", tens8); end
      drive(0, 15, 0, 0);
      checks++; if (tens8 !== 4'd1 || pulse8 !== 1'b0) begin errors++; $display("FAIL invalid_ignored: got %0d/%b want 1/0", tens8, pulse8); end
      drive(1, 1, 0, 0);
      checks++; if (tens8 !== 4'd1 || locked8 !== 1'b1) begin errors++; $display("FAIL tens_hold: got %0d/%b want 1/1", tens8, locked8); end
      do_reset();
      drive(1, 1, 0, 0); drive(1, 0, 0, 0);
      checks++; if (dir8 !== 1'b1 || locked8 !== 1'b1) begin errors++; $display("FAIL lock_down: got dir=%b locked=%b want 1/1", dir8, locked8); end
      drive(1, 9, 0, 0);
      checks++; if (tens8 !== 4'd9) begin errors++; $display("FAIL tens_wrap_down: got %0d want 9", tens8); end
   endtask

   task automatic test_bounce();
      do_reset();
      drive(1, 8, 0, 0); drive(1, 9, 0, 0);
      checks++; if (dir8 !== 1'b0 || locked8 !== 1'b1) begin errors++; $display("FAIL bounce_pre: got %b/%b want 0/1", dir8, locked8); end
      drive(1, 8, 0, 0);
      checks++; if (dir8 !== 1'b1 || pulse8 !== 1'b0 || locked8 !== 1'b1) begin errors++; $display("FAIL bounce_flip: got dir=%b pulse=%b locked=%b want 1/0/1", dir8, pulse8, locked8); end
      drive(1, 7, 0, 0);
      checks++; if (pulse8 !== 1'b0 || cnt8 !== 8'd0 || tens8 !== 4'd0) begin errors++; $display("FAIL bounce_track: got %b/%0d/%0d want 0/0/0", pulse8, cnt8, tens8); end
   endtask

   task automatic test_seq_err();
      do_reset();
      drive(1, 3, 0, 0); drive(1, 4, 0, 0); drive(1, 7, 0, 0);
      checks++; if (code8 !== 2'd2 || pulse8 !== 1'b1) begin errors++; $display("FAIL seq_code: got %0d/%b want 2/1", code8, pulse8); end
      checks++; if (cnt8 !== 8'd1 || locked8 !== 1'b0) begin errors++; $display("FAIL seq_count: got %0d/%b want 1/0", cnt8, locked8); end
      drive(1, 8, 0, 0);
      checks++; if (code8 !== 2'd0 || pulse8 !== 1'b0) begin errors++; $display("FAIL code_return: got %0d/%b want 0/0", code8, pulse8); end
      drive(1, 9, 0, 0);
      checks++; if (locked8 !== 1'b1 || dir8 !== 1'b0) begin errors++; $display("FAIL relock: got %b/%b want 1/0", locked8, dir8); end
   endtask

   task automatic test_badval_load();
      do_reset();
      drive(1, 3, 0, 0); drive(1, 4, 0, 0);
      drive(1, 12, 0, 0);
      checks++; if (code8 !== 2'd1 || pulse8 !== 1'b1 || locked8 !== 1'b0) begin errors++; $display("FAIL badval: got %0d/%b/%b want 1/1/0", code8, pulse8, locked8); end
      // prev must be untouched by the bad value: 5 now acquires, 6 locks up
      drive(1, 5, 0, 0);
      checks++; if (locked8 !== 1'b0 || pulse8 !== 1'b0) begin errors++; $display("FAIL idle_after_bad: got %b/%b want 0/0", locked8, pulse8); end
      drive(1, 6, 0, 0); drive(1, 7, 0, 0);
      drive(1, 6, 1, 0);
      checks++; if (locked8 !== 1'b0 || pulse8 !== 1'b0 || dir8 !== 1'b0) begin errors++; $display("FAIL load_acq: got %b/%b/%b want 0/0/0", locked8, pulse8, dir8); end
      drive(1, 5, 0, 0);
      checks++; if (locked8 !== 1'b1 || dir8 !== 1'b1) begin errors++; $display("FAIL load_relock: got %b/%b want 1/1", locked8, dir8); end
   endtask

   task automatic test_saturate_clr();
      do_reset();
      for (int i = 0; i < 5; i++) drive(1, 10 + i, 0, 0);
      checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL sat_w2: got %0d want 3", cnt2); end
      checks++; if (cnt8 !== 8'd5) begin errors++; $display("FAIL cnt_w8: got %0d want 5", cnt8); end
      drive(1, 15, 0, 1);
      checks++; if (cnt8 !== 8'd0 || cnt2 !== 2'd0 || pulse8 !== 1'b1 || code8 !== 2'd1) begin errors++; $display("FAIL clr_err: got %0d/%0d/%b/%0d want 0/0/1/1", cnt8, cnt2, pulse8, code8); end
      drive(1, 8, 0, 0); drive(1, 9, 0, 0); drive(1, 0, 0, 1);
      checks++; if (tens8 !== 4'd0 || locked8 !== 1'b1) begin errors++; $display("FAIL clr_wrap: got %0d/%b want 0/1", tens8, locked8); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1, 2, 0, 0); drive(1, 3, 0, 0); drive(1, 11, 0, 0); drive(1, 4, 0, 0); drive(1, 5, 0, 0);
      do_reset();
      checks++; if (locked8 !== 1'b0 || cnt8 !== 8'd0 || dir8 !== 1'b0) begin errors++; $display("FAIL reset_mid: got %b/%0d/%b want 0/0/0", locked8, cnt8, dir8); end
      drive(1, 6, 0, 0);
      checks++; if (locked8 !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: got %b want 0", locked8); end
   endtask

   task automatic test_random();
      int d, sel;
      bit v, ld, c;
      do_reset();
      for (int n = 0; n < 800; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2, 3: d = (m_prev + 1) % 10;
            4, 5:       d = (m_prev + 9) % 10;
            6:          d = m_prev;
            7, 8:       d = $urandom_range(0, 9);
            default:    d = $urandom_range(0, 15);
         endcase
         v  = ($urandom_range(0, 99) < 85);
         ld = ($urandom_range(0, 24) == 0);
         c  = ($urandom_range(0, 39) == 0);
         drive(v, d, ld, c);
         checks++; if (locked8 !== (m_mode == 2)) begin errors++; $display("FAIL rnd_locked n=%0d: got %b want %0d", n, locked8, m_mode == 2); end
         checks++; if (dir8 !== m_dir[0]) begin errors++; $display("FAIL rnd_dir n=%0d: got %b want %0d", n, dir8, m_dir); end
         checks++; if (tens8 !== m_tens[3:0]) begin errors++; $display("FAIL rnd_tens n=%0d: got %0d want %0d", n, tens8, m_tens); end
         checks++; if (pulse8 !== e_pulse[0]) begin errors++; $display("FAIL rnd_pulse n=%0d: got %b want %0d", n, pulse8, e_pulse); end
         checks++; if (code8 !== e_code[1:0]) begin errors++; $display("FAIL rnd_code n=%0d: got %0d want %0d", n, code8, e_code); end
         checks++; if (cnt8 !== m_cnt8[7:0]) begin errors++; $display("FAIL rnd_cnt8 n=%0d: got %0d want %0d", n, cnt8, m_cnt8); end
         checks++; if (cnt2 !== m_cnt2[1:0]) begin errors++; $display("FAIL rnd_cnt2 n=%0d: got %0d want %0d", n, cnt2, m_cnt2); end
      end
   endtask

   initial begin
      sif.in_valid = 1'b0; sif.in_digit = 4'd0; sif.load_seen = 1'b0;
      model_reset();
      test_reset();
      test_lock_up();
      test_wrap();
      test_bounce();
      test_seq_err();
      test_badval_load();
      test_saturate_clr();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_seq_monitor.md
BCD_SEQ_MONITOR -- requirements
Module: bcd_seq_monitor

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8: width of the saturating error counter.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port reset_n, input, 1: reset, synchronous, active-low; clock clk.
REQ-004 SHALL have port in_valid, input, 1: in_digit is a new counter sample this cycle.
REQ-005 SHALL have port in_digit, input, 4: observed mod-10 counter value.
REQ-006 SHALL have port load_seen, input, 1: upstream counter was parallel-loaded (qualified by in_valid).
REQ-007 SHALL have port clr, input, 1: clear tens and err_count.
REQ-008 SHALL have port locked, output, 1: direction acquired, tracking.
REQ-009 SHALL have port dir, output, 1: inferred direction, 0 = up, 1 = down.
REQ-010 SHALL have port tens, output, 4: BCD wrap digit, 0..9.
REQ-011 SHALL have port err_pulse, output, 1: one-cycle error strobe.
REQ-012 SHALL have port err_code, output, 2: 0 none, 1 BADVAL (digit > 9), 2 SEQ (illegal step).
REQ-013 SHALL have port err_count, output, ERR_CNT_W: saturating error total.

Function
REQ-014 SHALL register all outputs; response to a sample appears the cycle after in_valid.
REQ-015 SHALL ignore in_digit and load_seen while in_valid = 0; state, prev and outputs hold; err_pulse = 0.
REQ-016 SHALL implement states IDLE (no reference), ACQ (reference held, direction unknown) and LOCK (tracking); locked = 1 only in LOCK.
REQ-017 SHALL define succ(d) = (d == 9) ? 0 : d + 1 and pred(d) = (d == 0) ? 9 : d - 1, operating on 4 bits.
REQ-018 SHALL treat in_digit > 9 as highest priority in every state: err_code = 1, err_pulse, state -> IDLE, prev unchanged.
REQ-019 SHALL apply load_seen with a legal digit as second priority: prev = in_digit, state -> ACQ, no error, tens unchanged, dir unchanged.
REQ-020 IDLE: a legal digit SHALL set prev = in_digit, state -> ACQ.
REQ-021 ACQ: digit == succ(prev) -> dir = 0, LOCK; digit == pred(prev) -> dir = 1, LOCK; digit == prev -> stay (stall); otherwise SEQ error, stay ACQ. In every case prev = digit.
REQ-022 LOCK: digit == prev SHALL be a legal stall with no error.
REQ-023 LOCK, dir = 0: digit == succ(prev) is legal; a 9->0 step SHALL increment tens modulo 10 (9 -> 0).
REQ-024 LOCK, dir = 1: digit == pred(prev) is legal; a 0->9 step SHALL decrement tens modulo 10 (0 -> 9).
REQ-025 LOCK bounce: dir = 0 with prev = 9 and digit = 8, or dir = 1 with prev = 0 and digit = 1, SHALL flip dir, stay in LOCK, leave tens unchanged, raise no error.
REQ-026 LOCK: any other digit SHALL raise SEQ (err_code = 2), set state -> ACQ and prev = digit, and leave tens unchanged.
REQ-027 err_code SHALL return to 0 on any cycle without an error.
REQ-028 err_count SHALL increment on every err_pulse and saturate at 2^ERR_CNT_W - 1.
REQ-029 clr SHALL zero tens and err_count next cycle; it overrides a coincident increment/wrap, but err_pulse and err_code still fire.
REQ-030 clr SHALL NOT change state, prev or dir.

Reset
REQ-031 reset_n = 0 at a clk edge SHALL force state IDLE, prev = 0, dir = 0, tens = 0, err_count = 0, err_pulse = 0, err_code = 0, locked = 0, with priority over all inputs, including mid-acquisition.

Structure
REQ-032 Package bcd_mon_pkg SHALL hold the state enum, the err_code constants and MAX_DIGIT = 9.
REQ-033 Sub-module mod10_step SHALL compute succ/pred combinationally and be instantiated once.

Verification
REQ-034 Scenario 1: reset, then samples 3,4,5 -> locked = 1 after the 4 response, dir = 0, no errors.
REQ-035 Scenario 2: up stream 7,8,9,0,1 -> tens 0 -> 1 on the 0 response. Down stream 1,0,9 from tens = 0 -> tens = 9.
REQ-036 Scenario 3: bounce 8,9,8,7 -> dir flips 0 -> 1 after the second 8, no err_pulse.
REQ-037 Scenario 4: while locked up at 4, sample 7 -> err_code = 2, err_count = 1, locked = 0. Then 8,9 -> relock up.
REQ-038 Scenario 5: sample 12 -> err_code = 1, state IDLE. Load_seen with 6 while locked -> ACQ, no error.
REQ-039 Scenario 6: ERR_CNT_W = 2 with 5 errors -> err_count holds 3. clr coincident with an error -> err_count = 0 and err_pulse = 1.
